// File: rtl/fifo_drain_stream.sv
// Read-side engine for a synchronous FIFO: pops a programmed burst through the
// FIFO read port and streams it out over valid/ready via a 2-entry skid buffer.
module fifo_drain_stream #(
    parameter int WIDTH   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W:0]   words_left_o,
    output logic               fifo_cs_o,
    output logic               fifo_rd_en_o,
    input  logic               fifo_empty_i,
    input  logic [WIDTH-1:0]   fifo_data_i,
    output logic               m_valid_o,
    output logic [WIDTH-1:0]   m_data_o,
    input  logic               m_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [BURST_W:0] CNT_ONE = (BURST_W+1)'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_done_nxt;
    logic [BURST_W:0]   r_issue_cnt;
    logic [BURST_W:0]   r_words_left;
    logic               r_inflight;
    logic [1:0]         r_buf_cnt;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_pop;
    logic               w_start;
    logic [2:0]         w_occ;
    logic [BURST_W:0]   w_len;

    assign w_accept = (r_buf_cnt != 2'd0) && m_ready_i;
    assign w_last   = w_accept && (r_words_left == CNT_ONE);
    assign w_start  = (r_state == ST_IDLE) && start_i;
    assign w_len    = (burst_len_i == '0) ? {1'b1, {BURST_W{1'b0}}}
                                          : {1'b0, burst_len_i};

    // A word leaving this cycle frees its slot, so the buffer can refill while streaming.
    assign w_occ = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_accept};
    assign w_pop = (r_state == ST_RUN) && !fifo_empty_i
                   && (r_issue_cnt != '0) && (w_occ < 3'd2);

    assign fifo_rd_en_o = w_pop;
    assign fifo_cs_o    = r_busy;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign words_left_o = r_words_left;
    assign m_valid_o    = (r_buf_cnt != 2'd0);
    assign m_data_o     = r_head;

    // Next-state decode; the burst ends on the handshake of its final word.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_issue_cnt == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // Control registers: state, status flags and burst counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_issue_cnt  <= '0;
            r_words_left <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_inflight <= w_pop;
            if (w_start) begin
                r_issue_cnt  <= w_len;
                r_words_left <= w_len;
            end else begin
                if (w_pop) begin
                    r_issue_cnt <= r_issue_cnt - CNT_ONE;
                end
                if (w_accept && (r_words_left != '0)) begin
                    r_words_left <= r_words_left - CNT_ONE;
                end
            end
        end
    end

    // Output buffer: FIFO data lands at the tail the cycle after its pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_buf_cnt <= 2'd0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            case (r_buf_cnt)
                2'd0: begin
                    if (r_inflight) begin
                        r_head    <= fifo_data_i;
                        r_buf_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({r_inflight, w_accept})
                        2'b11: r_head <= fifo_data_i;
                        2'b10: begin
                            r_tail    <= fifo_data_i;
                            r_buf_cnt <= 2'd2;
                        end
                        2'b01: r_buf_cnt <= 2'd0;
                        default: r_buf_cnt <= 2'd1;
                    endcase
                end
                2'd2: begin
                    if (w_accept) begin
                        r_head <= r_tail;
                        if (r_inflight) begin
                            r_tail <= fifo_data_i;
                        end else begin
                            r_buf_cnt <= 2'd1;
                        end
                    end
                end
                default: r_buf_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_stream.sv
// Directed bench for fifo_drain_stream with a behavioural registered-read FIFO
// on the read port and a handshake monitor on the output stream.
module tb_fifo_drain_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] burst_len;
    logic       busy;
    logic       done;
    logic [4:0] words_left;
    logic       cs;
    logic       rd_en;
    logic       empty;
    logic [7:0] fdata = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: data registered on the pop edge
    logic [7:0] mem [0:63];
    int         wptr = 0;
    int         rptr = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    // monitor state
    int         cyc = 0;
    int         n_pops = 0;
    int         rd_while_empty = 0;
    logic [7:0] got [$];
    int         hs_cyc [$];

    fifo_drain_stream #(.WIDTH(8), .BURST_W(4)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .burst_len_i  (burst_len),
        .busy_o       (busy),
        .done_o       (done),
        .words_left_o (words_left),
        .fifo_cs_o    (cs),
        .fifo_rd_en_o (rd_en),
        .fifo_empty_i (empty),
        .fifo_data_i  (fdata),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_ready_i    (m_ready)
    );

    always #5 clk = ~clk;

    assign empty = (wptr == rptr);

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wptr % 64] <= wr_data;
            wptr <= wptr + 1;
        end
        if (rd_en && (wptr != rptr)) begin
            fdata <= mem[rptr % 64];
            rptr  <= rptr + 1;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            hs_cyc.push_back(cyc);
        end
        if (rd_en) n_pops = n_pops + 1;
        if (rd_en && empty) rd_while_empty = rd_while_empty + 1;
    end

    task automatic push_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic start_burst(input logic [3:0] len);
        start     = 1'b1;
        burst_len = len;
        @(negedge clk);
        start     = 1'b0;
        burst_len = 4'd0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, words_left, cs, rd_en, m_valid, m_data} !== 19'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {busy, done, words_left, cs, rd_en, m_valid, m_data});
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_w [0:2];
        int base;
        bit ok;
        exp_w = '{8'd1, 8'd10, 8'd100};
        base  = got.size();
        for (int i = 0; i < 3; i++) push_word(exp_w[i]);
        start_burst(4'd3);
        n_checks++;
        if ({busy, cs, words_left} !== {1'b1, 1'b1, 5'd3}) begin
            n_errors++;
            $display("FAIL t1_start: busy/cs/left got %b/%b/%0d expected 1/1/3", busy, cs, words_left);
        end
        wait_done(50, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $display("FAIL t1_done_timeout: done got 0 expected 1");
        end
        n_checks++;
        if (got.size() !== base + 3) begin
            n_errors++;
            $display("FAIL t1_count: got %0d words expected 3", got.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got[base+i] !== exp_w[i]) begin
                    n_errors++;
                    $display("FAIL t1_word%0d: got %0d expected %0d", i, got[base+i], exp_w[i]);
                end
            end
            n_checks++;
            if (cyc - (hs_cyc[$] - 1) !== 1) begin
                n_errors++;
                $display("FAIL t1_done_delay: got %0d cycles expected 1", cyc - (hs_cyc[$] - 1));
            end
        end
        n_checks++;
        if ({busy, words_left} !== {1'b0, 5'd0}) begin
            n_errors++;
            $display("FAIL t1_end_state: busy/left got %b/%0d expected 0/0", busy, words_left);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL t1_done_pulse: done got %b expected 0", done);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int pops0;
        bit ok;
        base  = got.size();
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
        start_burst(4'd8);
        wait_done(60, ok);
        n_checks++;
        if (ok !== 1'b1 || got.size() !== base + 8) begin
            n_errors++;
            $display("FAIL t2_count: done %b words %0d expected 1/8", ok, got.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got[base+i] !== 8'h40 + 8'(i)) begin
                    n_errors++;
                    $display("FAIL t2_word%0d: got %0h expected %0h", i, got[base+i], 8'h40 + 8'(i));
                end
            end
            n_checks++;
            if (hs_cyc[$] - hs_cyc[base] !== 7) begin
                n_errors++;
                $display("FAIL t2_b2b: span got %0d expected 7", hs_cyc[$] - hs_cyc[base]);
            end
        end
        n_checks++;
        if (n_pops - pops0 !== 8 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL t2_pops: pops %0d empty %b expected 8/1", n_pops - pops0, empty);
        end
    endtask

    task automatic test_stall();
        int base;
        int pops0;
        int unstable;
        bit ok;
        base     = got.size();
        pops0    = n_pops;
        unstable = 0;
        for (int i = 0; i < 4; i++) push_word(8'h31 + 8'(i));
        m_ready = 1'b0;
        start_burst(4'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1 && m_data !== 8'h31) unstable++;
        end
        n_checks++;
        if (n_pops - pops0 !== 2) begin
            n_errors++;
            $display("FAIL t3_pops: got %0d expected 2", n_pops - pops0);
        end
        n_checks++;
        if ({m_valid, m_data} !== {1'b1, 8'h31} || unstable !== 0) begin
            n_errors++;
            $display("FAIL t3_hold: valid/data %b/%0h unstable %0d expected 1/31/0", m_valid, m_data, unstable);
        end
        m_ready = 1'b1;
        wait_done(40, ok);
        n_checks++;
        if (ok !== 1'b1 || got.size() !== base + 4) begin
            n_errors++;
            $display("FAIL t3_count: done %b words %0d expected 1/4", ok, got.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[base+i] !== 8'h31 + 8'(i)) begin
                    n_errors++;
                    $display("FAIL t3_word%0d: got %0h expected %0h", i, got[base+i], 8'h31 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_empty_fifo();
        logic [7:0] exp_w [0:3];
        int base;
        int rwe0;
        bit ok;
        exp_w = '{8'd1, 8'd2, 8'd4, 8'd8};
        base  = got.size();
        rwe0  = rd_while_empty;
        start_burst(4'd4);
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk);
            push_word(exp_w[i]);
        end
        wait_done(60, ok);
        n_checks++;
        if (rd_while_empty - rwe0 !== 0) begin
            n_errors++;
            $display("FAIL t4_rd_empty: got %0d pops while empty expected 0", rd_while_empty - rwe0);
        end
        n_checks++;
        if (ok !== 1'b1 || got.size() !== base + 4) begin
            n_errors++;
            $display("FAIL t4_count: done %b words %0d expected 1/4", ok, got.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[base+i] !== exp_w[i]) begin
                    n_errors++;
                    $display("FAIL t4_word%0d: got %0d expected %0d", i, got[base+i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_max_len();
        int base;
        int pops0;
        bit ok;
        base  = got.size();
        pops0 = n_pops;
        for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
        start_burst(4'd0);
        n_checks++;
        if (words_left !== 5'd16) begin
            n_errors++;
            $display("FAIL t5_left: got %0d expected 16", words_left);
        end
        wait_done(100, ok);
        n_checks++;
        if (ok !== 1'b1 || got.size() !== base + 16 || n_pops - pops0 !== 16) begin
            n_errors++;
            $display("FAIL t5_count: done %b words %0d pops %0d expected 1/16/16",
                     ok, got.size() - base, n_pops - pops0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (got[base+i] !== 8'h80 + 8'(i)) begin
                    n_errors++;
                    $display("FAIL t5_word%0d: got %0h expected %0h", i, got[base+i], 8'h80 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        int waited;
        logic [7:0] exp_next;
        bit ok;
        base = got.size();
        for (int i = 0; i < 7; i++) push_word(8'hA1 + 8'(i));
        start_burst(4'd5);
        waited = 0;
        while (got.size() < base + 2 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (got.size() < base + 2) begin
            n_errors++;
            $display("FAIL t6_progress: got %0d words expected 2", got.size() - base);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, words_left, cs, rd_en, m_valid, m_data} !== 19'd0) begin
            n_errors++;
            $display("FAIL t6_reset_outputs: got %0h expected 0",
                     {busy, done, words_left, cs, rd_en, m_valid, m_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_next = mem[rptr % 64];
        base     = got.size();
        start_burst(4'd1);
        wait_done(30, ok);
        n_checks++;
        if (ok !== 1'b1 || got.size() !== base + 1) begin
            n_errors++;
            $display("FAIL t6_restart: done %b words %0d expected 1/1", ok, got.size() - base);
        end else begin
            n_checks++;
            if (got[base] !== exp_next) begin
                n_errors++;
                $display("FAIL t6_next_word: got %0h expected %0h", got[base], exp_next);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = 4'd0;
        m_ready   = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_back_to_back();
        test_stall();
        test_empty_fifo();
        test_max_len();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
